inet_checksum_accumulator: RTL

- Streaming byte-in Internet checksum generator (RFC 1071) for the UDP/TCP datapath.
- Packs incoming bytes big-endian into 16-bit words and folds them into a running sum with 16-bit one's-complement addition (end-around carry), the same arithmetic as the team's adder.
- At packet end, emits the inverted sum plus the byte count to the header-insertion stage.
- Sits between the payload byte stream and the UDP/TCP header builder.

---
 rtl/inet_checksum_accumulator.sv | 133 +++++++++++++
 1 files changed

// File: rtl/inet_checksum_accumulator.sv
// Streaming Internet checksum (RFC 1071) generator.
// Bytes are packed big-endian into 16-bit words and folded into a running
// one's-complement sum; at packet end the inverted sum and byte count are
// presented on a valid/ready result port.
module inet_checksum_accumulator #(
  parameter int unsigned UDP_ZERO_FIX = 0,
  parameter int unsigned LEN_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [15:0]          seed,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  input  logic                 in_last,
  output logic                 in_ready,
  output logic [15:0]          out_csum,
  output logic [LEN_WIDTH-1:0] out_len,
  output logic                 out_valid,
  input  logic                 out_ready
);

  typedef enum logic [0:0] {StAccum, StOut} state_e;

  state_e               state_q, state_d;
  logic [15:0]          sum_q, sum_d;
  logic [7:0]           hi_q, hi_d;
  logic                 phase_q, phase_d;
  logic                 first_q, first_d;
  logic [LEN_WIDTH-1:0] count_q, count_d;
  logic [15:0]          csum_q, csum_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;

  // 16-bit one's-complement add with end-around carry.
  function automatic logic [15:0] oc_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[15:0] + {15'd0, s[16]};
  endfunction

  logic                 accept;
  logic [15:0]          base;
  logic [15:0]          word;
  logic [15:0]          folded;
  logic [15:0]          inv_sum;
  logic [LEN_WIDTH-1:0] count_inc;

  // Datapath helpers shared by the next-state logic.
  always_comb begin
    accept    = in_valid && (state_q == StAccum);
    base      = first_q ? seed : sum_q;
    // In phase 0 the byte is the high half; a lone final byte is zero-padded.
    word      = phase_q ? {hi_q, in_data} : {in_data, 8'h00};
    folded    = oc_add(base, word);
    inv_sum   = ~folded;
    count_inc = (&count_q) ? count_q : count_q + 1'b1;
  end

  // Next-state logic for the accumulate/output FSM.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    hi_d    = hi_q;
    phase_d = phase_q;
    first_d = first_q;
    count_d = count_q;
    csum_d  = csum_q;
    len_d   = len_q;

    unique case (state_q)
      StAccum: begin
        if (accept) begin
          first_d = 1'b0;
          count_d = count_inc;
          if (!phase_q && !in_last) begin
            hi_d    = in_data;
            sum_d   = base;
            phase_d = 1'b1;
          end else begin
            sum_d   = folded;
            phase_d = 1'b0;
          end
          if (in_last) begin
            state_d = StOut;
            len_d   = count_inc;
            csum_d  = ((UDP_ZERO_FIX != 0) && (inv_sum == 16'h0000)) ? 16'hFFFF : inv_sum;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          state_d = StAccum;
          sum_d   = 16'h0000;
          phase_d = 1'b0;
          first_d = 1'b1;
          count_d = '0;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StAccum;
      sum_q   <= 16'h0000;
      hi_q    <= 8'h00;
      phase_q <= 1'b0;
      first_q <= 1'b1;
      count_q <= '0;
      csum_q  <= 16'h0000;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      hi_q    <= hi_d;
      phase_q <= phase_d;
      first_q <= first_d;
      count_q <= count_d;
      csum_q  <= csum_d;
      len_q   <= len_d;
    end
  end

  // Handshake outputs follow the FSM state; results are held in registers.
  always_comb begin
    in_ready  = (state_q == StAccum);
    out_valid = (state_q == StOut);
    out_csum  = csum_q;
    out_len   = len_q;
  end

endmodule
